// File: rtl/alu_pkg.sv
// Shared ALU op encodings, RV opcode/funct constants and the instruction decoder.
package alu_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;

    typedef logic [OP_W-1:0] alu_op_t;

    localparam alu_op_t OP_AND = 2'b00;
    localparam alu_op_t OP_OR  = 2'b01;
    localparam alu_op_t OP_ADD = 2'b10;
    localparam alu_op_t OP_SUB = 2'b11;

    localparam logic [OPC_W-1:0] OPC_OP    = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OPIMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    localparam logic [F3_W-1:0] F3_ADD = 3'b000;
    localparam logic [F3_W-1:0] F3_OR  = 3'b110;
    localparam logic [F3_W-1:0] F3_AND = 3'b111;

    // Decoded control for one instruction; illegal ops keep op=AND and zero args.
    typedef struct packed {
        alu_op_t op;
        logic    illegal;
        logic    use_imm;
    } dec_t;

    function automatic dec_t decode(input logic [OPC_W-1:0] opcode,
                                    input logic [F3_W-1:0]  funct3,
                                    input logic [F7_W-1:0]  funct7);
        dec_t d;
        d.op      = OP_AND;
        d.illegal = 1'b1;
        d.use_imm = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD: begin d.op = OP_ADD; d.illegal = 1'b0; end
                        F3_AND: begin d.op = OP_AND; d.illegal = 1'b0; end
                        F3_OR:  begin d.op = OP_OR;  d.illegal = 1'b0; end
                        default: ;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    d.op      = OP_SUB;
                    d.illegal = 1'b0;
                end
            end
            OPC_OPIMM: begin
                d.use_imm = 1'b1;
                case (funct3)
                    F3_ADD: begin d.op = OP_ADD; d.illegal = 1'b0; end
                    F3_AND: begin d.op = OP_AND; d.illegal = 1'b0; end
                    F3_OR:  begin d.op = OP_OR;  d.illegal = 1'b0; end
                    default: ;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                d.op      = OP_ADD;
                d.illegal = 1'b0;
                d.use_imm = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-side and result-side handshake bundle for alu_issue.
interface alu_issue_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_opcode;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [WIDTH-1:0] in_rs1;
    logic [WIDTH-1:0] in_rs2;
    logic [WIDTH-1:0] in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_result, out_illegal, retired
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_result, out_illegal, retired
    );
endinterface

// File: rtl/alu_issue_alu.sv
// Shared 2-bit-op combinational ALU; arithmetic wraps modulo 2^WIDTH.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the operation result.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Two-stage execute front end: decode into an issue register, drive the ALU
// from it, register the result and hand it downstream.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);

    dec_t             dec;
    logic [WIDTH-1:0] dec_arg1;
    logic [WIDTH-1:0] dec_arg2;

    logic             s1_valid;
    alu_op_t          s1_op;
    logic [WIDTH-1:0] s1_arg1;
    logic [WIDTH-1:0] s1_arg2;
    logic             s1_illegal;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic             out_illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic [WIDTH-1:0] alu_y;
    logic             s1_take;
    logic             s2_take;
    logic             out_hs;

    // Decode incoming instruction and select operands; illegal ops carry zero args.
    always_comb begin
        dec      = decode(bus.in_opcode, bus.in_funct3, bus.in_funct7);
        dec_arg1 = '0;
        dec_arg2 = '0;
        if (!dec.illegal) begin
            dec_arg1 = bus.in_rs1;
            dec_arg2 = dec.use_imm ? bus.in_imm : bus.in_rs2;
        end
    end

    // Handshake flow; in_ready looks through to out_ready so a draining s1 can refill.
    always_comb begin
        out_hs  = out_valid_q & bus.out_ready;
        s2_take = s1_valid & (~out_valid_q | bus.out_ready);
        s1_take = bus.in_valid & (~s1_valid | s2_take);
    end

    assign bus.in_ready    = ~s1_valid | s2_take;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_illegal = out_illegal_q;
    assign bus.retired     = retired_q;

    alu #(.WIDTH(WIDTH)) u_alu (
        .op (s1_op),
        .a  (s1_arg1),
        .b  (s1_arg2),
        .y  (alu_y)
    );

    // Stage 1 issue register: reload on accept, empty when drained without refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= OP_AND;
            s1_arg1    <= '0;
            s1_arg2    <= '0;
            s1_illegal <= 1'b0;
        end else if (s1_take) begin
            s1_valid   <= 1'b1;
            s1_op      <= dec.op;
            s1_arg1    <= dec_arg1;
            s1_arg2    <= dec_arg2;
            s1_illegal <= dec.illegal;
        end else if (s2_take) begin
            s1_valid   <= 1'b0;
        end
    end

    // Stage 2 result register: load from ALU, hold while stalled, clear valid on a bare handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_illegal_q <= 1'b0;
        end else if (s2_take) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= s1_illegal ? '0 : alu_y;
            out_illegal_q <= s1_illegal;
        end else if (out_hs) begin
            out_valid_q   <= 1'b0;
        end
    end

    // Saturating count of completed output handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (out_hs && (retired_q != {CNT_W{1'b1}})) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

endmodule
